// File: rtl/ctrl_noc_pkt_arbiter.sv
// ctrl_noc_pkt_arbiter: packet-atomic round-robin merge of NUM_SRCS ctrl-NoC flit streams.
// Latency: 0 cycles; the source-to-destination path is purely combinational with no flit storage.
// Backpressure: dst_arb_rdy is passed straight to the granted source only; other sources see rdy=0.
// Build option: define CTRL_NOC_ARB_STATS_EN to add per-source tail-flit packet counters (arb_pkt_cnt).

`ifndef CTRL_NOC1_DATA_W
`define CTRL_NOC1_DATA_W 64
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif

module ctrl_noc_pkt_arbiter #(
  parameter int NUM_SRCS   = 4,
  parameter int NUM_SRCS_W = $clog2(NUM_SRCS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRCS-1:0]                  src_arb_val,
  input  logic [NUM_SRCS*`CTRL_NOC1_DATA_W-1:0] src_arb_data,
  output logic [NUM_SRCS-1:0]                  arb_src_rdy,
  output logic                                 arb_dst_val,
  output logic [`CTRL_NOC1_DATA_W-1:0]         arb_dst_data,
  input  logic                                 dst_arb_rdy,
  output logic [NUM_SRCS-1:0]                  arb_grant_oh,
  output logic                                 arb_busy
`ifdef CTRL_NOC_ARB_STATS_EN
  ,
  output logic [NUM_SRCS*32-1:0]               arb_pkt_cnt
`endif
);

  localparam int DW = `CTRL_NOC1_DATA_W;
  localparam int LW = `MSG_LENGTH_WIDTH;
  // routing_hdr_flit, MSB first: chipid(14) x(8) y(8) fbits(4) msg_len(LW) msg_type(8) mshr_tag(8) rsvd
  localparam int HDR_LEN_LSB = DW - 34 - LW;

  localparam logic [1:0] ST_ARB  = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;

  logic [1:0]            state;
  logic [NUM_SRCS_W-1:0] prio_ptr;
  logic [NUM_SRCS_W-1:0] grant_idx;
  logic [LW-1:0]         flit_cnt;

  logic                  win_vld;
  logic [NUM_SRCS_W-1:0] win_idx;
  logic                  sel_vld;
  logic [NUM_SRCS_W-1:0] sel_idx;
  logic [NUM_SRCS-1:0]   sel_oh;
  logic                  xfer;
  logic [LW-1:0]         hdr_len;

  // Wrap-safe increment for any NUM_SRCS, power of two or not.
  function automatic logic [NUM_SRCS_W-1:0] ptr_inc(input logic [NUM_SRCS_W-1:0] idx);
    if (idx == NUM_SRCS_W'(NUM_SRCS - 1)) return '0;
    else return idx + NUM_SRCS_W'(1);
  endfunction

  // Round-robin search: first valid source at or above prio_ptr, wrapping.
  always_comb begin
    int cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      cand = int'(prio_ptr) + k;
      if (cand >= NUM_SRCS) cand = cand - NUM_SRCS;
      if (src_arb_val[NUM_SRCS_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = NUM_SRCS_W'(cand);
      end
    end
  end

  // Select the granted source: live winner in ARB, locked source in BODY; all quiet in reset.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    arb_busy = 1'b0;
    case (state)
      ST_ARB: begin
        sel_vld = win_vld;
        sel_idx = win_idx;
      end
      ST_BODY: begin
        sel_vld  = 1'b1;
        sel_idx  = grant_idx;
        arb_busy = 1'b1;
      end
      default: begin
        sel_vld  = 1'bx;
        sel_idx  = 'x;
        arb_busy = 1'bx;
      end
    endcase
    if (!rst_n) begin
      sel_vld  = 1'b0;
      arb_busy = 1'b0;
    end
  end

  // Combinational output mux and handshake.
  always_comb begin
    sel_oh          = '0;
    sel_oh[sel_idx] = 1'b1;
    arb_grant_oh    = sel_vld ? sel_oh : '0;
    arb_src_rdy     = {NUM_SRCS{dst_arb_rdy}} & arb_grant_oh;
    arb_dst_val     = |(src_arb_val & arb_grant_oh);
    arb_dst_data    = sel_vld ? src_arb_data[sel_idx*DW +: DW] : '0;
    xfer            = arb_dst_val & dst_arb_rdy;
    hdr_len         = arb_dst_data[HDR_LEN_LSB +: LW];
  end

  // Packet FSM: header picks the owner, body flits count down to the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      prio_ptr  <= '0;
      grant_idx <= '0;
      flit_cnt  <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (xfer) begin
            if (hdr_len == '0) begin
              prio_ptr <= ptr_inc(win_idx);
            end else begin
              grant_idx <= win_idx;
              flit_cnt  <= hdr_len;
              state     <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (xfer) begin
            flit_cnt <= flit_cnt - LW'(1);
            if (flit_cnt == LW'(1)) begin
              state    <= ST_ARB;
              prio_ptr <= ptr_inc(grant_idx);
            end
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

`ifdef CTRL_NOC_ARB_STATS_EN
  logic        pkt_tail;
  logic [31:0] pkt_cnt [NUM_SRCS];

  assign pkt_tail = xfer & (((state == ST_ARB) & (hdr_len == '0)) |
                            ((state == ST_BODY) & (flit_cnt == LW'(1))));

  // Count completed packets per source on the tail flit; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRCS; i++) pkt_cnt[i] <= '0;
    end else if (pkt_tail) begin
      pkt_cnt[sel_idx] <= pkt_cnt[sel_idx] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_SRCS; g++) begin : g_cnt
    assign arb_pkt_cnt[g*32 +: 32] = pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_ctrl_noc_pkt_arbiter.sv
// Directed bench for ctrl_noc_pkt_arbiter: 4 sources, 64-bit flits, 8-bit msg_len.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Per-source flit lists model the sources; transfers are logged for order checks.
module tb_ctrl_noc_pkt_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_arb_val;
  logic [N*DW-1:0] src_arb_data;
  logic [N-1:0]    arb_src_rdy;
  logic            arb_dst_val;
  logic [DW-1:0]   arb_dst_data;
  logic            dst_arb_rdy;
  logic [N-1:0]    arb_grant_oh;
  logic            arb_busy;
`ifdef CTRL_NOC_ARB_STATS_EN
  logic [N*32-1:0] arb_pkt_cnt;
`endif

  always #5 clk = ~clk;

  ctrl_noc_pkt_arbiter #(.NUM_SRCS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_arb_val(src_arb_val), .src_arb_data(src_arb_data),
    .arb_src_rdy(arb_src_rdy), .arb_dst_val(arb_dst_val),
    .arb_dst_data(arb_dst_data), .dst_arb_rdy(dst_arb_rdy),
    .arb_grant_oh(arb_grant_oh), .arb_busy(arb_busy)
`ifdef CTRL_NOC_ARB_STATS_EN
    , .arb_pkt_cnt(arb_pkt_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] fl [N][8];
  int            n_fl [N];
  int            rd [N];
  logic [N-1:0]  hold;
  logic [DW-1:0] log_dat [32];
  logic [N-1:0]  log_gnt [32];
  int            log_n;

  function automatic logic [DW-1:0] mk_hdr(input int s, input int len, input int tag);
    return {14'(s), 8'h11, 8'h22, 4'h3, 8'(len), 8'hA5, 8'(tag), 6'h0};
  endfunction

  function automatic logic [DW-1:0] mk_body(input int s, input int tag, input int n);
    return {8'hB0, 8'(s), 8'(tag), 8'(n), 32'hC0DE_0000};
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (rd[i] < n_fl[i]) p = 1'b1;
    return p;
  endfunction

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin n_fl[i] = 0; rd[i] = 0; end
    hold  = '0;
    log_n = 0;
  endtask

  task automatic load(input int s, input int len, input int tag);
    fl[s][n_fl[s]] = mk_hdr(s, len, tag);
    n_fl[s]++;
    for (int b = 1; b <= len; b++) begin
      fl[s][n_fl[s]] = mk_body(s, tag, b);
      n_fl[s]++;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < N; i++) begin
      src_arb_val[i] = (rd[i] < n_fl[i]) && !hold[i];
      src_arb_data[i*DW +: DW] = (rd[i] < n_fl[i]) ? fl[i][rd[i]] : '0;
    end
    #1;
  endtask

  task automatic step();
    if (arb_dst_val && dst_arb_rdy && log_n < 32) begin
      log_dat[log_n] = arb_dst_data;
      log_gnt[log_n] = arb_grant_oh;
      log_n++;
    end
    for (int i = 0; i < N; i++) if (arb_src_rdy[i] && src_arb_val[i]) rd[i]++;
    @(posedge clk);
    @(negedge clk);
    settle();
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (pending() && c < max) begin step(); c++; end
    n_cmp++;
    if (pending()) begin n_err++; $display("FAIL drain_timeout: flits still queued after %0d cycles", max); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dst_arb_rdy = 1'b1;
    clear_srcs();
    settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dst_arb_rdy = 1'b1;
    clear_srcs();
    load(1, 2, 1);
    load(2, 0, 1);
    settle();
    @(posedge clk);
    @(negedge clk);
    settle();
    n_cmp++; if (arb_dst_val !== 1'b0) begin n_err++; $display("FAIL reset_dst_val: got %b want 0", arb_dst_val); end
    n_cmp++; if (arb_src_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_src_rdy: got %b want 0000", arb_src_rdy); end
    n_cmp++; if (arb_grant_oh !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", arb_grant_oh); end
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", arb_busy); end
    n_cmp++; if (arb_dst_data !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", arb_dst_data); end
`ifdef CTRL_NOC_ARB_STATS_EN
    n_cmp++; if (arb_pkt_cnt !== '0) begin n_err++; $display("FAIL reset_pkt_cnt: got %h want 0", arb_pkt_cnt); end
`endif
    rst_n = 1'b1;
    settle();
    n_cmp++; if (arb_grant_oh !== 4'b0010) begin n_err++; $display("FAIL reset_first_grant: got %b want 0010", arb_grant_oh); end
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d [3];
    do_reset();
    load(1, 2, 7);
    settle();
    exp_d[0] = mk_hdr(1, 2, 7);
    exp_d[1] = mk_body(1, 7, 1);
    exp_d[2] = mk_body(1, 7, 2);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (arb_grant_oh !== 4'b0010) begin n_err++; $display("FAIL single_grant c%0d: got %b want 0010", c, arb_grant_oh); end
      n_cmp++; if (arb_busy !== (c > 0)) begin n_err++; $display("FAIL single_busy c%0d: got %b want %b", c, arb_busy, c > 0); end
      n_cmp++; if (arb_src_rdy !== 4'b0010) begin n_err++; $display("FAIL single_src_rdy c%0d: got %b want 0010", c, arb_src_rdy); end
      step();
    end
    n_cmp++; if (log_n !== 3) begin n_err++; $display("FAIL single_count: got %0d want 3", log_n); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (log_dat[i] !== exp_d[i]) begin n_err++; $display("FAIL single_data %0d: got %h want %h", i, log_dat[i], exp_d[i]); end
    end
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", arb_busy); end
    load(1, 0, 8);
    load(2, 0, 8);
    settle();
    n_cmp++; if (arb_grant_oh !== 4'b0100) begin n_err++; $display("FAIL single_prio_next: got %b want 0100", arb_grant_oh); end
    drain(20);
  endtask

  task automatic test_contention();
    int s, tag;
    do_reset();
    for (int i = 0; i < N; i++) load(i, 1, i + 1);
    load(0, 1, 9);
    settle();
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (arb_dst_val !== 1'b1) begin n_err++; $display("FAIL contention_no_idle c%0d: got %b want 1", c, arb_dst_val); end
      step();
    end
    drain(20);
    n_cmp++; if (log_n !== 10) begin n_err++; $display("FAIL contention_count: got %0d want 10", log_n); end
    for (int p = 0; p < 5; p++) begin
      s   = p % 4;
      tag = (p < 4) ? p + 1 : 9;
      n_cmp++; if (log_dat[2*p] !== mk_hdr(s, 1, tag)) begin n_err++; $display("FAIL contention_hdr p%0d: got %h want %h", p, log_dat[2*p], mk_hdr(s, 1, tag)); end
      n_cmp++; if (log_dat[2*p+1] !== mk_body(s, tag, 1)) begin n_err++; $display("FAIL contention_body p%0d: got %h want %h", p, log_dat[2*p+1], mk_body(s, tag, 1)); end
      n_cmp++; if (log_gnt[2*p+1] !== 4'(1 << s)) begin n_err++; $display("FAIL contention_gnt p%0d: got %b want %b", p, log_gnt[2*p+1], 4'(1 << s)); end
    end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] exp_d [5];
    do_reset();
    load(2, 3, 3);
    settle();
    n_cmp++; if (arb_grant_oh !== 4'b0100) begin n_err++; $display("FAIL bubble_first_grant: got %b want 0100", arb_grant_oh); end
    step();
    load(0, 0, 4);
    settle();
    step();
    hold = 4'b0100;
    settle();
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (arb_dst_val !== 1'b0) begin n_err++; $display("FAIL bubble_dst_val c%0d: got %b want 0", c, arb_dst_val); end
      n_cmp++; if (arb_grant_oh !== 4'b0100) begin n_err++; $display("FAIL bubble_grant c%0d: got %b want 0100", c, arb_grant_oh); end
      n_cmp++; if (arb_src_rdy[0] !== 1'b0) begin n_err++; $display("FAIL bubble_src0_rdy c%0d: got %b want 0", c, arb_src_rdy[0]); end
      step();
    end
    hold = '0;
    settle();
    drain(20);
    exp_d[0] = mk_hdr(2, 3, 3);
    exp_d[1] = mk_body(2, 3, 1);
    exp_d[2] = mk_body(2, 3, 2);
    exp_d[3] = mk_body(2, 3, 3);
    exp_d[4] = mk_hdr(0, 0, 4);
    n_cmp++; if (log_n !== 5) begin n_err++; $display("FAIL bubble_count: got %0d want 5", log_n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (log_dat[i] !== exp_d[i]) begin n_err++; $display("FAIL bubble_order %0d: got %h want %h", i, log_dat[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    load(0, 1, 5);
    for (int c = 0; c < 4; c++) begin
      dst_arb_rdy = rdy_pat[c];
      settle();
      n_cmp++; if (arb_src_rdy !== {3'b000, rdy_pat[c]}) begin n_err++; $display("FAIL bp_src_rdy c%0d: got %b want %b", c, arb_src_rdy, {3'b000, rdy_pat[c]}); end
      if (c > 0) begin
        n_cmp++; if (arb_dst_data !== mk_body(0, 5, 1)) begin n_err++; $display("FAIL bp_data_hold c%0d: got %h want %h", c, arb_dst_data, mk_body(0, 5, 1)); end
      end
      step();
    end
    dst_arb_rdy = 1'b1;
    settle();
    n_cmp++; if (log_n !== 2) begin n_err++; $display("FAIL bp_count: got %0d want 2", log_n); end
    n_cmp++; if (arb_dst_val !== 1'b0) begin n_err++; $display("FAIL bp_idle_after: got %b want 0", arb_dst_val); end
  endtask

  task automatic test_header_only();
    logic [N-1:0] exp_g [3] = '{4'b1000, 4'b0001, 4'b1000};
    do_reset();
    load(2, 0, 1);
    settle();
    step();
    load(3, 0, 2);
    load(3, 0, 3);
    load(0, 0, 4);
    settle();
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (arb_grant_oh !== exp_g[c]) begin n_err++; $display("FAIL hdronly_grant c%0d: got %b want %b", c, arb_grant_oh, exp_g[c]); end
      n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL hdronly_busy c%0d: got %b want 0", c, arb_busy); end
      step();
    end
    n_cmp++; if (log_n !== 4) begin n_err++; $display("FAIL hdronly_count: got %0d want 4", log_n); end
    n_cmp++; if (log_dat[2] !== mk_hdr(0, 0, 4)) begin n_err++; $display("FAIL hdronly_src0_next: got %h want %h", log_dat[2], mk_hdr(0, 0, 4)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load(1, 3, 1);
    settle();
    step();
    step();
    n_cmp++; if (arb_busy !== 1'b1) begin n_err++; $display("FAIL areset_mid_body: got %b want 1", arb_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (arb_dst_val !== 1'b0) begin n_err++; $display("FAIL areset_dst_val: got %b want 0", arb_dst_val); end
    n_cmp++; if (arb_src_rdy !== 4'b0000) begin n_err++; $display("FAIL areset_src_rdy: got %b want 0000", arb_src_rdy); end
    n_cmp++; if (arb_grant_oh !== 4'b0000) begin n_err++; $display("FAIL areset_grant: got %b want 0000", arb_grant_oh); end
    n_cmp++; if (arb_busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", arb_busy); end
    clear_srcs();
    settle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef CTRL_NOC_ARB_STATS_EN
    n_cmp++; if (arb_pkt_cnt !== '0) begin n_err++; $display("FAIL areset_cnt_clear: got %h want 0", arb_pkt_cnt); end
`endif
    load(1, 0, 2);
    load(2, 0, 2);
    settle();
    n_cmp++; if (arb_grant_oh !== 4'b0010) begin n_err++; $display("FAIL areset_win1: got %b want 0010", arb_grant_oh); end
    step();
    n_cmp++; if (arb_grant_oh !== 4'b0100) begin n_err++; $display("FAIL areset_win2: got %b want 0100", arb_grant_oh); end
    step();
    n_cmp++; if (log_n !== 2) begin n_err++; $display("FAIL areset_count: got %0d want 2", log_n); end
`ifdef CTRL_NOC_ARB_STATS_EN
    n_cmp++; if (arb_pkt_cnt !== {32'd0, 32'd1, 32'd1, 32'd0}) begin n_err++; $display("FAIL areset_cnt: got %h want 0,1,1,0", arb_pkt_cnt); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    dst_arb_rdy = 1'b1;
    hold        = '0;
    test_reset();
    test_single();
    test_contention();
    test_bubble();
    test_backpressure();
    test_header_only();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
